// File: rtl/aes_pkg.sv
// aes_pkg -- shared types, tables and helpers for the iterative AES byte-substitution stage.
//   aes_state_t      128-bit AES state, [0:127], byte i = bits [8*i +: 8]
//   aes_byte_t       one state byte
//   INV_SBOX / SBOX  inverse / forward S-box tables (SBOX only with INV_SUB_BYTES_FWD_EN)
//   AES_NBYTES       bytes per state
//   inv_sb_state_e   controller states
//   byte_lsb()       first bit position of byte idx inside an aes_state_t
// Build macro: INV_SUB_BYTES_FWD_EN adds the forward table.
package aes_pkg;

   typedef logic [0:127] aes_state_t;
   typedef logic [7:0]   aes_byte_t;

   localparam int AES_NBYTES = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} inv_sb_state_e;

   localparam aes_byte_t INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

`ifdef INV_SUB_BYTES_FWD_EN
   localparam aes_byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
`endif

   function automatic logic [6:0] byte_lsb(input int idx);
      return 7'(8 * idx);
   endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if -- valid/ready input and output channels of the byte-substitution stage.
//   crypte/in_valid/in_ready     input state channel
//   message/out_valid/out_ready  result state channel
//   master: producer/consumer side, slave: the substitution block.
interface inv_sub_bytes_seq_if;
   import aes_pkg::*;

   aes_state_t crypte;
   logic       in_valid;
   logic       in_ready;
   aes_state_t message;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output crypte, in_valid, out_ready,
      input  in_ready, message, out_valid
   );

   modport slave (
      input  crypte, in_valid, out_ready,
      output in_ready, message, out_valid
   );
endinterface

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox -- combinational single-byte S-box lookup.
//   din   in   8   byte to substitute
//   dout  out  8   substituted byte
//   inv   in   1   1 = inverse table, 0 = forward table (only with INV_SUB_BYTES_FWD_EN)
// Build macro: INV_SUB_BYTES_FWD_EN adds the forward table and the inv select.
module aes_inv_sbox
   import aes_pkg::*;
(
`ifdef INV_SUB_BYTES_FWD_EN
   input  logic      inv,
`endif
   input  aes_byte_t din,
   output aes_byte_t dout
);

`ifdef INV_SUB_BYTES_FWD_EN
   assign dout = inv ? INV_SBOX[din] : SBOX[din];
`else
   assign dout = INV_SBOX[din];
`endif

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq -- iterative AES InvSubBytes, BYTES_PER_CYCLE bytes per clock,
// one state in flight.
//   clk   in   1   clock, posedge
//   rst   in   1   synchronous reset, active-high
//   inv   in   1   1 = InvSubBytes, 0 = SubBytes (only with INV_SUB_BYTES_FWD_EN)
//   bus   slave modport of inv_sub_bytes_seq_if (crypte/in_valid/in_ready,
//         message/out_valid/out_ready)
// Parameter BYTES_PER_CYCLE: 1, 2, 4, 8 or 16.
// Build macro: INV_SUB_BYTES_FWD_EN adds the inv port and the forward table.
//
// state | meaning
// IDLE  | in_ready high, waiting for a state
// RUN   | substituting BYTES_PER_CYCLE bytes per cycle, ascending index
// DONE  | out_valid high, result held until out_ready
module inv_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
)
(
   input  logic clk,
   input  logic rst,
`ifdef INV_SUB_BYTES_FWD_EN
   input  logic inv,
`endif
   inv_sub_bytes_seq_if.slave bus
);

   localparam int NSTEP = AES_NBYTES / BYTES_PER_CYCLE;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
       BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
      $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   inv_sb_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   aes_state_t       data_q, data_d;
`ifdef INV_SUB_BYTES_FWD_EN
   logic             inv_q, inv_d;
`endif

   aes_byte_t lane_in  [BYTES_PER_CYCLE];
   aes_byte_t lane_out [BYTES_PER_CYCLE];

   logic last_step;
   assign last_step = (cnt_q == CNT_W'(NSTEP - 1));

   // Byte lanes: lane l works on byte cnt*BPC + l of the current step.
   always_comb begin
      for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
         lane_in[l] = data_q[byte_lsb(int'(cnt_q) * BYTES_PER_CYCLE + l) +: 8];
      end
   end

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      aes_inv_sbox u_sbox (
`ifdef INV_SUB_BYTES_FWD_EN
         .inv  (inv_q),
`endif
         .din  (lane_in[g]),
         .dout (lane_out[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
         inv_q   <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
`ifdef INV_SUB_BYTES_FWD_EN
         inv_q   <= inv_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
`ifdef INV_SUB_BYTES_FWD_EN
      inv_d   = inv_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = RUN;
               cnt_d   = '0;
               data_d  = bus.crypte;
`ifdef INV_SUB_BYTES_FWD_EN
               inv_d   = inv;
`endif
            end
         end
         RUN: begin
            for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
               data_d[byte_lsb(int'(cnt_q) * BYTES_PER_CYCLE + l) +: 8] = lane_out[l];
            end
            if (last_step) state_d = DONE;
            else           cnt_d   = cnt_q + CNT_W'(1);
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE) && !rst;
      bus.out_valid = (state_q == DONE);
      bus.message   = data_q;
   end

endmodule
